// File: rtl/nrisc_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : nrisc_arb_pkg                                         |
// | Purpose  : Shared types and constants for the NRISC memory       |
// |            arbiter: grant-state encoding, grant IDs, bus width.  |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
package nrisc_arb_pkg;

  // Default address/data width of the NRISC memory port
  localparam int NRISC_TAM_DEFAULT = 16;

  // Arbiter grant state machine
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_D  = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  // Identifies which requester owns (or last owned) the memory port
  typedef logic gnt_id_t;
  localparam gnt_id_t GNT_FETCH = 1'b0;
  localparam gnt_id_t GNT_DATA  = 1'b1;

endpackage : nrisc_arb_pkg
`default_nettype wire

// File: rtl/nrisc_arb_timeout.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : nrisc_arb_timeout                                     |
// | Purpose  : Watchdog for a granted memory access. 8-bit counter   |
// |            with clear and enable; expire flags the last cycle    |
// |            the arbiter is willing to wait for mem_ack.           |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module nrisc_arb_timeout #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  // Counter value on which the access is abandoned
  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] count;

  // Count cycles spent in a grant state; cleared whenever no grant is active
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  assign expire = enable && (count == LIMIT);

endmodule : nrisc_arb_timeout
`default_nettype wire

// File: rtl/nrisc_mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : nrisc_mem_arbiter                                     |
// | Purpose  : Shares one memory port between instruction fetch and  |
// |            core load/store traffic. Grant FSM with req/ack on    |
// |            every port and a watchdog that aborts silent memory.  |
// | Config   : NRISC_ARB_RR_EN defined   -> round-robin on ties      |
// |            NRISC_ARB_RR_EN undefined -> data beats fetch         |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module nrisc_mem_arbiter
  import nrisc_arb_pkg::*;
#(
  parameter int TAM     = NRISC_TAM_DEFAULT,
  parameter int TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst,
  // instruction fetch port
  input  logic           if_req,
  input  logic [TAM-1:0] if_addr,
  output logic           if_ack,
  output logic [TAM-1:0] if_rdata,
  output logic           if_err,
  // core data port
  input  logic           d_req,
  input  logic           d_we,
  input  logic [TAM-1:0] d_addr,
  input  logic [TAM-1:0] d_wdata,
  output logic           d_ack,
  output logic [TAM-1:0] d_rdata,
  output logic           d_err,
  // shared memory port
  output logic           mem_req,
  output logic           mem_we,
  output logic [TAM-1:0] mem_addr,
  output logic [TAM-1:0] mem_wdata,
  input  logic [TAM-1:0] mem_rdata,
  input  logic           mem_ack,
  // status
  output logic           busy
);

  arb_state_t     state;
  gnt_id_t        winner;     // owner of the current transfer
  logic [TAM-1:0] res_data;   // completed transfer result, handed out in DONE
  logic           res_err;
  logic           take_data;  // IDLE decision: grant the data port
  logic           in_grant;
  logic           wd_expire;

`ifdef NRISC_ARB_RR_EN
  gnt_id_t        last_gnt;   // most recent grant, used to break ties
`endif

  assign in_grant = (state == GNT_IF) || (state == GNT_D);
  assign busy     = (state != IDLE);

  // Arbitration decision for a request seen in IDLE
  always_comb begin
    take_data = 1'b0;
    if (d_req && !if_req) begin
      take_data = 1'b1;
    end else if (d_req && if_req) begin
`ifdef NRISC_ARB_RR_EN
      take_data = (last_gnt == GNT_FETCH);
`else
      take_data = 1'b1;
`endif
    end
  end

  nrisc_arb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (!in_grant),
    .enable (in_grant),
    .expire (wd_expire)
  );

`ifdef NRISC_ARB_RR_EN
  // Remember who was granted last so the other side wins the next tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt <= GNT_FETCH;
    end else if ((state == IDLE) && (if_req || d_req)) begin
      last_gnt <= take_data ? GNT_DATA : GNT_FETCH;
    end
  end
`endif

  // Grant FSM: latch the winner, run the memory access, then pulse its ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      winner    <= GNT_FETCH;
      res_data  <= '0;
      res_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      if_rdata  <= '0;
      if_err    <= 1'b0;
      d_ack     <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            mem_req <= 1'b1;
            if (take_data) begin
              state     <= GNT_D;
              winner    <= GNT_DATA;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end else begin
              state     <= GNT_IF;
              winner    <= GNT_FETCH;
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
            end
          end
        end
        GNT_IF, GNT_D: begin
          // mem_ack takes precedence over a watchdog expiry in the same cycle
          if (mem_ack) begin
            mem_req  <= 1'b0;
            res_data <= mem_we ? '0 : mem_rdata;
            res_err  <= 1'b0;
            state    <= DONE;
          end else if (wd_expire) begin
            mem_req  <= 1'b0;
            res_data <= '0;
            res_err  <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
          if (winner == GNT_DATA) begin
            d_ack   <= 1'b1;
            d_rdata <= res_data;
            d_err   <= res_err;
          end else begin
            if_ack   <= 1'b1;
            if_rdata <= res_data;
            if_err   <= res_err;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule : nrisc_mem_arbiter
`default_nettype wire

// File: tb/tb_nrisc_mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_nrisc_mem_arbiter                                  |
// | Purpose  : Directed self-checking bench for nrisc_mem_arbiter.   |
// |            Honours NRISC_ARB_RR_EN for the tie-break vectors.    |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module tb_nrisc_mem_arbiter;

  localparam int TAM     = 16;
  localparam int TIMEOUT = 15;

  logic           clk;
  logic           rst;
  logic           if_req;
  logic [TAM-1:0] if_addr;
  logic           if_ack;
  logic [TAM-1:0] if_rdata;
  logic           if_err;
  logic           d_req;
  logic           d_we;
  logic [TAM-1:0] d_addr;
  logic [TAM-1:0] d_wdata;
  logic           d_ack;
  logic [TAM-1:0] d_rdata;
  logic           d_err;
  logic           mem_req;
  logic           mem_we;
  logic [TAM-1:0] mem_addr;
  logic [TAM-1:0] mem_wdata;
  logic [TAM-1:0] mem_rdata;
  logic           mem_ack;
  logic           busy;

  int n_checks = 0;
  int n_fail   = 0;

  // memory model controls
  int             mem_lat   = 1;
  bit             mem_en    = 1'b1;
  bit             stray_ack = 1'b0;
  logic [TAM-1:0] mem_word  = '0;
  int             mem_cnt   = 0;

  nrisc_mem_arbiter #(
    .TAM     (TAM),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .if_err    (if_err),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: acks so that mem_ack is sampled mem_lat edges after mem_req rose
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = stray_ack;
      if (mem_req) begin
        mem_cnt++;
        if (mem_en && (mem_cnt == mem_lat)) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_word;
        end
      end else begin
        mem_cnt = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Count edges until the selected ack is seen; -1 if it never comes
  task automatic wait_ack(input bit want_data, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = -1;
    for (int i = 1; i <= 40; i++) begin
      if (!seen) begin
        @(posedge clk); #1;
        if (want_data ? d_ack : if_ack) begin
          seen = 1'b1;
          cyc  = i;
        end
      end
    end
  endtask

  // Raise both requests together and check service order and timing
  task automatic run_tie(input bit data_first, input bit store, input string tag);
    int cyc;
    if_req   = 1'b1;  if_addr = 16'h0040;
    d_req    = 1'b1;  d_we    = store;
    d_addr   = 16'h0300; d_wdata = 16'h4321;
    mem_lat  = 1;     mem_en  = 1'b1;  mem_word = 16'h7777;
    @(posedge clk); #1;
    check({tag, " first mem_addr"}, 32'(mem_addr), data_first ? 32'h0300 : 32'h0040);
    check({tag, " first mem_we"}, 32'(mem_we), (data_first && store) ? 32'd1 : 32'd0);
    wait_ack(data_first, cyc);
    check({tag, " first latency"}, cyc, 32'd2);
    if (data_first) d_req = 1'b0; else if_req = 1'b0;
    wait_ack(!data_first, cyc);
    check({tag, " second latency"}, cyc, 32'd3);
    check({tag, " if_rdata"}, 32'(if_rdata), 32'h7777);
    check({tag, " d_rdata"}, 32'(d_rdata), store ? 32'h0 : 32'h7777);
    if_req = 1'b0;
    d_req  = 1'b0;
    d_we   = 1'b0;
  endtask

  initial begin
    int cyc;
    int acks;
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk); #1;

    // reset state
    check("reset busy",     32'(busy),     32'd0);
    check("reset mem_req",  32'(mem_req),  32'd0);
    check("reset mem_addr", 32'(mem_addr), 32'd0);
    check("reset if_ack",   32'(if_ack),   32'd0);
    check("reset d_ack",    32'(d_ack),    32'd0);
    rst = 1'b0;

    // first tie after reset: data wins in both arbitration modes
    run_tie(1'b1, 1'b0, "tie1");

    // fetch with a 2-cycle memory
    if_req = 1'b1; if_addr = 16'h0010; mem_lat = 2; mem_word = 16'hA5A5;
    @(posedge clk); #1;
    check("fetch mem_req",  32'(mem_req),  32'd1);
    check("fetch mem_addr", 32'(mem_addr), 32'h0010);
    check("fetch mem_we",   32'(mem_we),   32'd0);
    check("fetch busy",     32'(busy),     32'd1);
    wait_ack(1'b0, cyc);
    check("fetch latency",  cyc,            32'd3);
    check("fetch if_rdata", 32'(if_rdata), 32'hA5A5);
    check("fetch if_err",   32'(if_err),   32'd0);
    check("fetch mem_req low", 32'(mem_req), 32'd0);
    if_req = 1'b0;

    // load
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0100; mem_lat = 1; mem_word = 16'h5A5A;
    @(posedge clk); #1;
    wait_ack(1'b1, cyc);
    check("load latency", cyc,             32'd2);
    check("load d_rdata", 32'(d_rdata),   32'h5A5A);
    d_req = 1'b0;

    // store: returned word must be discarded
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234; mem_word = 16'hBEEF;
    @(posedge clk); #1;
    check("store mem_we",    32'(mem_we),    32'd1);
    check("store mem_addr",  32'(mem_addr),  32'h0200);
    check("store mem_wdata", 32'(mem_wdata), 32'h1234);
    wait_ack(1'b1, cyc);
    check("store latency", cyc,            32'd2);
    check("store d_rdata", 32'(d_rdata),  32'h0);
    check("store d_err",   32'(d_err),    32'd0);
    d_req = 1'b0; d_we = 1'b0;

    // second tie, last grant was data
`ifdef NRISC_ARB_RR_EN
    run_tie(1'b0, 1'b1, "tie2");
`else
    run_tie(1'b1, 1'b1, "tie2");
`endif

    // stray mem_ack while idle is ignored
    stray_ack = 1'b1;
    @(posedge clk); #1;
    stray_ack = 1'b0;
    check("stray busy",  32'(busy),           32'd0);
    check("stray acks",  32'({if_ack, d_ack}), 32'd0);

    // memory never answers: watchdog abort
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0400; mem_en = 1'b0;
    @(posedge clk); #1;
    wait_ack(1'b1, cyc);
    check("timeout latency", cyc,            32'(TIMEOUT + 1));
    check("timeout d_err",   32'(d_err),    32'd1);
    check("timeout d_rdata", 32'(d_rdata),  32'h0);
    check("timeout mem_req", 32'(mem_req),  32'd0);
    d_req = 1'b0; mem_en = 1'b1;

    // mem_ack coincides with watchdog expiry: ack wins
    if_req = 1'b1; if_addr = 16'h0020; mem_lat = TIMEOUT; mem_word = 16'hC3C3;
    @(posedge clk); #1;
    wait_ack(1'b0, cyc);
    check("race latency",  cyc,            32'(TIMEOUT + 1));
    check("race if_err",   32'(if_err),   32'd0);
    check("race if_rdata", 32'(if_rdata), 32'hC3C3);
    if_req = 1'b0;

    // asynchronous reset in the middle of a data grant
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0500; d_wdata = 16'h9999; mem_en = 1'b0;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst mem_req",  32'(mem_req),  32'd0);
    check("rst mem_we",   32'(mem_we),   32'd0);
    check("rst busy",     32'(busy),     32'd0);
    check("rst d_err",    32'(d_err),    32'd0);
    check("rst if_rdata", 32'(if_rdata), 32'h0);
    d_req = 1'b0; mem_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    acks = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (if_ack || d_ack) acks++;
    end
    check("rst no ack", acks, 32'd0);

    // fresh fetch after reset
    if_req = 1'b1; if_addr = 16'h0030; mem_lat = 2; mem_word = 16'h0F0F;
    @(posedge clk); #1;
    check("post-rst mem_addr", 32'(mem_addr), 32'h0030);
    wait_ack(1'b0, cyc);
    check("post-rst latency",  cyc,            32'd3);
    check("post-rst if_rdata", 32'(if_rdata), 32'h0F0F);
    if_req = 1'b0;

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_nrisc_mem_arbiter
`default_nettype wire
